md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Multiply/divide unit in the EX stage. It owns the HI/LO registers and runs MULT/MULTU/DIV/DIVU with fixed multi-cycle latency.
- It executes MTHI/MTLO immediately.
- It drives `busy` back to the hazard unit. The hazard unit stalls decode on `busy` or on a pending start, so this block never sees an overlapping operation in normal flow.

Parameters:
- MUL_LAT, 5, busy cycles for MULT/MULTU (must be ≥1)
- DIV_LAT, 10, busy cycles for DIV/DIVU (must be ≥1)

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- start  input  1  EX-stage instruction is a HI/LO operation (mult/div/mthi/mtlo)
- valid  input  1  EX-stage instruction is valid (not a bubble or flushed)
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO 6,7=no-op
- A  input  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- B  input  32  rt operand (divisor / multiplier)
- busy  output  1  operation in progress
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (async, resetn=0): state=IDLE, cnt=0, busy=0, HI=0, LO=0, pending result=0. Reset mid-operation aborts it and no result is ever written.
- Accept condition: `fire = start & valid & (state==IDLE)`.
  - start while busy is ignored; the in-flight op is unaffected.
  - start with valid=0 is ignored.
- States and busy:
  - States are IDLE, MUL and DIV.
  - busy is registered: busy = (state != IDLE).
- MULT/MULTU on fire:
  - Latch the 64-bit product into an internal result register. MULT is signed × signed; MULTU is unsigned.
  - state←MUL, cnt←MUL_LAT−1.
- DIV/DIVU on fire:
  - Latch quotient and remainder. DIV is signed, truncating toward zero; the remainder takes the sign of the dividend. DIVU is unsigned.
  - state←DIV, cnt←DIV_LAT−1.
- MTHI/MTLO on fire:
  - At the same edge, HI←A (MTHI) or LO←A (MTLO).
  - state stays IDLE and busy stays 0. The new value is visible in the next cycle.
- op 6/7 on fire: no effect.
- MUL/DIV states:
  - When cnt≠0: cnt←cnt−1.
  - When cnt==0: commit and return to IDLE at that edge. For MUL, HI←product[63:32] and LO←product[31:0]. For DIV, HI←remainder and LO←quotient.
  - Net timing: busy is high for exactly MUL_LAT or DIV_LAT cycles after the accepting edge. HI/LO update at the same edge that busy falls.
  - A new start may be accepted in the first cycle busy is low.
- HI/LO are held unchanged while busy, so reads during busy return the old values. The hazard unit prevents such reads.
- Divide by zero (B=0), DIV and DIVU: LO←32'hFFFFFFFF, HI←A. Full latency still applies.
- Signed overflow (DIV, A=32'h80000000, B=32'hFFFFFFFF): LO←32'h80000000, HI←0.
- Width rules:
  - Signed ops sign-extend operands to 64 bits. Unsigned ops zero-extend.
  - cnt is 4 bits or $clog2(max(MUL_LAT,DIV_LAT)) bits, whichever is larger.

Test Plan:
- Signed multiply: reset, then MULT A=32'hFFFFFFFD (−3), B=7 → busy=1 for 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFEB. HI/LO stay 0 while busy.
- Unsigned multiply: MULTU A=32'hFFFFFFFF, B=2 → after 5 cycles HI=1, LO=32'hFFFFFFFE.
- Signed divide: DIV A=32'hFFFFFFF9 (−7), B=2 → busy for 10 cycles, then LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
- Divide corner cases:
  - DIVU A=7, B=0 → LO=32'hFFFFFFFF, HI=7.
  - DIV A=32'h80000000, B=32'hFFFFFFFF → LO=32'h80000000, HI=0.
- Move-to and gating:
  - MTHI A=32'h12345678 → HI updates next cycle, busy never rises.
  - MTLO with valid=0 → LO unchanged.
  - MTLO during an active MULT → ignored, and the MULT result commits normally.
- Reset mid-op: MULT 3×4, deassert resetn at busy cycle 2 → busy=0, HI=LO=0 immediately. After release, no stale commit occurs.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: EX-stage multiply/divide unit owning the HI/LO registers.
// Ports: clk, resetn (async low), start/valid/op/A/B request, busy, HI, LO.
module md_unit #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        valid,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CW   = ($clog2(MAXL) > 4) ? $clog2(MAXL) : 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   res_q, res_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic          fire;
    logic          sgn_mul, sgn_div;
    logic [63:0]   ext_a, ext_b, prod;
    logic [31:0]   mag_a, mag_b, dvsr;
    logic [31:0]   q_u, r_u, quot, rem;
    logic          neg_q, neg_r;

    assign fire = start & valid & (state_q == S_IDLE);

    // Low 64 bits of an extended-operand product are correct for both
    // signed and unsigned forms.
    always_comb begin
        sgn_mul = (op == OP_MULT);
        ext_a   = {{32{sgn_mul & A[31]}}, A};
        ext_b   = {{32{sgn_mul & B[31]}}, B};
        prod    = ext_a * ext_b;
    end

    // Signed divide works on magnitudes then fixes signs; the
    // 0x80000000 / -1 case falls out as q=0x80000000, r=0.
    always_comb begin
        sgn_div = (op == OP_DIV);
        mag_a   = (sgn_div & A[31]) ? (~A + 32'd1) : A;
        mag_b   = (sgn_div & B[31]) ? (~B + 32'd1) : B;
        dvsr    = (B == 32'd0) ? 32'd1 : mag_b;
        q_u     = mag_a / dvsr;
        r_u     = mag_a % dvsr;
        neg_q   = sgn_div & (A[31] ^ B[31]);
        neg_r   = sgn_div & A[31];
        quot    = neg_q ? (~q_u + 32'd1) : q_u;
        rem     = neg_r ? (~r_u + 32'd1) : r_u;
        if (B == 32'd0) begin
            quot = 32'hFFFF_FFFF;
            rem  = A;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE: begin
                if (fire) begin
                    unique case (op)
                        OP_MULT, OP_MULTU: begin
                            res_d   = prod;
                            state_d = S_MUL;
                            cnt_d   = CW'(MUL_LAT - 1);
                        end
                        OP_DIV, OP_DIVU: begin
                            res_d   = {rem, quot};
                            state_d = S_DIV;
                            cnt_d   = CW'(DIV_LAT - 1);
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    hi_d    = res_q[63:32];
                    lo_d    = res_q[31:0];
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed self-checking bench for md_unit.
// Drives inputs on the falling edge and samples there too.
module tb_md_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic        valid;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad   = 0;

    logic [31:0] mhi;
    logic [31:0] mlo;

    md_unit #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .resetn(resetn),
        .start (start),
        .valid (valid),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge; returns one falling edge later.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic v);
        start = 1'b1;
        valid = v;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
        valid = 1'b0;
        op    = 3'd7;
        A     = 32'd0;
        B     = 32'd0;
    endtask

    task automatic run_md(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input int lat, input logic [31:0] ehi,
                          input logic [31:0] elo);
        do_op(o, a, b, 1'b1);
        for (int i = 0; i < lat; i++) begin
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
            check({tag, "_hold_hi"}, HI, mhi);
            check({tag, "_hold_lo"}, LO, mlo);
            @(negedge clk);
        end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check({tag, "_hi"}, HI, ehi);
        check({tag, "_lo"}, LO, elo);
        mhi = ehi;
        mlo = elo;
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        valid  = 1'b0;
        op     = 3'd7;
        A      = 32'd0;
        B      = 32'd0;
        mhi    = 32'd0;
        mlo    = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        run_md("mult", 3'd0, 32'hFFFF_FFFD, 32'd7, 5,
               32'hFFFF_FFFF, 32'hFFFF_FFEB);
        // issued in the first cycle busy is low
        run_md("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5,
               32'h0000_0001, 32'hFFFF_FFFE);
        run_md("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_md("div_pos", 3'd2, 32'd100, 32'hFFFF_FFF9, 10,
               32'd2, 32'hFFFF_FFF2);
        run_md("divu0", 3'd3, 32'd7, 32'd0, 10,
               32'd7, 32'hFFFF_FFFF);
        run_md("div0", 3'd2, 32'hFFFF_FFF0, 32'd0, 10,
               32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_md("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10,
               32'd0, 32'h8000_0000);
        run_md("divu", 3'd3, 32'hFFFF_FFF9, 32'd2, 10,
               32'h0000_0001, 32'h7FFF_FFFC);

        do_op(3'd4, 32'h1234_5678, 32'd0, 1'b1);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        check("mthi_hi", HI, 32'h1234_5678);
        check("mthi_lo", LO, 32'h7FFF_FFFC);
        @(negedge clk);
        check("mthi_busy2", {31'd0, busy}, 32'd0);
        mhi = 32'h1234_5678;

        do_op(3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
        check("mtlo_nv_lo", LO, 32'h7FFF_FFFC);
        check("mtlo_nv_busy", {31'd0, busy}, 32'd0);

        do_op(3'd6, 32'hDEAD_BEEF, 32'd5, 1'b1);
        check("nop_busy", {31'd0, busy}, 32'd0);
        check("nop_hi", HI, 32'h1234_5678);
        check("nop_lo", LO, 32'h7FFF_FFFC);

        do_op(3'd5, 32'hA5A5_0001, 32'd0, 1'b1);
        check("mtlo_lo", LO, 32'hA5A5_0001);
        mlo = 32'hA5A5_0001;

        // MTLO arriving mid-MULT must be dropped
        do_op(3'd0, 32'd6, 32'd7, 1'b1);
        check("mx_busy1", {31'd0, busy}, 32'd1);
        do_op(3'd5, 32'h0000_CAFE, 32'd0, 1'b1);
        check("mx_busy2", {31'd0, busy}, 32'd1);
        check("mx_lo_hold", LO, 32'hA5A5_0001);
        repeat (3) @(negedge clk);
        check("mx_busy5", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("mx_idle", {31'd0, busy}, 32'd0);
        check("mx_hi", HI, 32'd0);
        check("mx_lo", LO, 32'd42);
        @(negedge clk);
        check("mx_lo_after", LO, 32'd42);

        // reset in busy cycle 2 aborts the MULT
        do_op(3'd0, 32'd3, 32'd4, 1'b1);
        @(negedge clk);
        check("rmid_busy", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        #1;
        check("rmid_busy0", {31'd0, busy}, 32'd0);
        check("rmid_hi", HI, 32'd0);
        check("rmid_lo", LO, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        check("rpost_busy", {31'd0, busy}, 32'd0);
        check("rpost_hi", HI, 32'd0);
        check("rpost_lo", LO, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
